// File: rtl/lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_checker
//
// Receive-side PRBS checker for the Fibonacci LFSR word generator. It uses the
// same polynomial, word width and bit ordering as the generator: bit 0 of each
// word is the oldest bit in time.
//
// Operation
// - HUNT:     seeds its history from the first non-zero beat.
// - VERIFY:   confirms LOCK_COUNT consecutive predicted beats.
// - LOCKED:   counts bit errors. It re-hunts after UNLOCK_ERRORS consecutive
//             errored beats.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   s_tvalid     : input beat valid
//   s_tready     : input ready (registered, 1 from the cycle after reset)
//   s_tdata      : received PRBS word, bit 0 oldest
//   clear_count  : synchronous clear of error_count (and bit_count)
//   locked       : high while in LOCKED
//   err_valid    : one-cycle pulse for an errored beat checked in LOCKED
//   err_bits     : number of bit errors in that beat
//   error_count  : saturating total of bit errors
//   bit_count    : saturating count of bits compared in LOCKED
//
// Build option
//   LFSR_PRBS_CHECKER_BIT_COUNT_EN
//     - Defined:   builds the 48-bit bit_count counter.
//     - Undefined: bit_count is tied to zero.
// -----------------------------------------------------------------------------
module lfsr_prbs_checker #(
  parameter int unsigned          POLY_DEGREE   = 7,
  parameter logic [POLY_DEGREE:1] POLYNOMIAL    = 7'b110_0000,
  parameter int unsigned          DATA_WIDTH    = 8,
  parameter int unsigned          LOCK_COUNT    = 4,
  parameter int unsigned          UNLOCK_ERRORS = 3,
  parameter int unsigned          ERR_CNT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [DATA_WIDTH-1:0]             s_tdata,
  input  logic                              clear_count,
  output logic                              locked,
  output logic                              err_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   err_bits,
  output logic [ERR_CNT_WIDTH-1:0]          error_count,
  output logic [47:0]                       bit_count
);

  localparam int unsigned EBW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned MCW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BCW  = $clog2(UNLOCK_ERRORS + 1);
  localparam int unsigned SUMW = ((ERR_CNT_WIDTH > EBW) ? ERR_CNT_WIDTH : EBW) + 1;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Elaboration-time parameter checks
  if (DATA_WIDTH < POLY_DEGREE) begin : g_width_check
    $error("lfsr_prbs_checker: DATA_WIDTH must be >= POLY_DEGREE");
  end
  if (LOCK_COUNT < 1 || UNLOCK_ERRORS < 1) begin : g_count_check
    $error("lfsr_prbs_checker: LOCK_COUNT and UNLOCK_ERRORS must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Unrolled recurrence. The window holds the history in its low POLY_DEGREE
  // bits, with the newest bit on top; the predicted bits are appended above.
  // A tap at delay k therefore sits k positions below the bit being produced.
  function automatic logic [DATA_WIDTH-1:0] predict_word(
    input logic [POLY_DEGREE-1:0] hist
  );
    logic [POLY_DEGREE+DATA_WIDTH-1:0] win;
    logic                              nb;
    win                  = '0;
    win[POLY_DEGREE-1:0] = hist;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      nb = 1'b0;
      for (int k = 1; k <= int'(POLY_DEGREE); k++) begin
        if (POLYNOMIAL[k]) begin
          nb = nb ^ win[int'(POLY_DEGREE) + i - k];
        end else begin
          nb = nb;
        end
      end
      win[int'(POLY_DEGREE) + i] = nb;
    end
    return win[POLY_DEGREE+DATA_WIDTH-1:POLY_DEGREE];
  endfunction

  // Number of set bits in a word
  function automatic logic [EBW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [EBW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      n = n + EBW'(v[i]);
    end
    return n;
  endfunction

  // Add a beat's error bits to the total, saturating at all-ones
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_add_err(
    input logic [ERR_CNT_WIDTH-1:0] base,
    input logic [EBW-1:0]           add
  );
    logic [SUMW-1:0] sum;
    sum = SUMW'(base) + SUMW'(add);
    if (sum[SUMW-1:ERR_CNT_WIDTH] != '0) begin
      return {ERR_CNT_WIDTH{1'b1}};
    end else begin
      return sum[ERR_CNT_WIDTH-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]               state_q,       state_d;
  logic [POLY_DEGREE-1:0]   hist_q,        hist_d;
  logic [MCW-1:0]           match_cnt_q,   match_cnt_d;
  logic [BCW-1:0]           bad_cnt_q,     bad_cnt_d;
  logic                     s_tready_q;
  logic                     locked_q,      locked_d;
  logic                     err_valid_q,   err_valid_d;
  logic [EBW-1:0]           err_bits_q,    err_bits_d;
  logic [ERR_CNT_WIDTH-1:0] error_count_q, error_count_d;
  logic [ERR_CNT_WIDTH-1:0] err_base_s;

  logic                     beat_s;
  logic                     beat_locked_s;
  logic [DATA_WIDTH-1:0]    expected_s;
  logic [DATA_WIDTH-1:0]    diff_s;
  logic [EBW-1:0]           diff_cnt_s;
  logic                     data_zero_s;

  assign beat_s      = s_tvalid && s_tready_q;
  assign expected_s  = predict_word(hist_q);
  assign diff_s      = s_tdata ^ expected_s;
  assign diff_cnt_s  = popcount(diff_s);
  assign data_zero_s = (s_tdata == '0);

  // Next-state logic: hunt / verify / locked sequencing and error detection
  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    match_cnt_d   = match_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    err_valid_d   = 1'b0;
    err_bits_d    = '0;
    beat_locked_s = 1'b0;
    if (beat_s) begin
      case (state_q)
        ST_HUNT: begin
          // An all-zero history is a fixed point of the LFSR, so never seed from it
          if (data_zero_s) begin
            state_d = ST_HUNT;
          end else begin
            hist_d      = s_tdata[DATA_WIDTH-1 -: POLY_DEGREE];
            match_cnt_d = '0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (diff_s == '0) begin
            hist_d = s_tdata[DATA_WIDTH-1 -: POLY_DEGREE];
            if (match_cnt_q + MCW'(1) == MCW'(LOCK_COUNT)) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              bad_cnt_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + MCW'(1);
            end
          end else if (data_zero_s) begin
            state_d     = ST_HUNT;
            match_cnt_d = '0;
          end else begin
            // Reseed from the mismatching beat and start the run again
            hist_d      = s_tdata[DATA_WIDTH-1 -: POLY_DEGREE];
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          beat_locked_s = 1'b1;
          // Advance on the expected bits so that errors do not propagate
          hist_d        = expected_s[DATA_WIDTH-1 -: POLY_DEGREE];
          err_bits_d    = diff_cnt_s;
          if (diff_cnt_s != '0) begin
            err_valid_d = 1'b1;
            if (bad_cnt_q + BCW'(1) == BCW'(UNLOCK_ERRORS)) begin
              state_d   = ST_HUNT;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BCW'(1);
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ST_HUNT;
          match_cnt_d = '0;
          bad_cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Error total: clear first, then add this beat's errors
  always_comb begin
    err_base_s    = clear_count ? '0 : error_count_q;
    error_count_d = sat_add_err(err_base_s, err_valid_d ? diff_cnt_s : EBW'(0));
    locked_d      = (state_d == ST_LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      hist_q        <= '0;
      match_cnt_q   <= '0;
      bad_cnt_q     <= '0;
      s_tready_q    <= 1'b0;
      locked_q      <= 1'b0;
      err_valid_q   <= 1'b0;
      err_bits_q    <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      match_cnt_q   <= match_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      s_tready_q    <= 1'b1;
      locked_q      <= locked_d;
      err_valid_q   <= err_valid_d;
      err_bits_q    <= err_bits_d;
      error_count_q <= error_count_d;
    end
  end

`ifdef LFSR_PRBS_CHECKER_BIT_COUNT_EN
  logic [47:0] bit_count_q, bit_count_d;
  logic [47:0] bit_base_s;
  logic [48:0] bit_sum_s;

  // Compared-bit total: clear first, then add one word per locked beat, saturating
  always_comb begin
    bit_base_s = clear_count ? 48'd0 : bit_count_q;
    bit_sum_s  = {1'b0, bit_base_s} + (beat_locked_s ? 49'(DATA_WIDTH) : 49'd0);
    if (bit_sum_s[48]) begin
      bit_count_d = {48{1'b1}};
    end else begin
      bit_count_d = bit_sum_s[47:0];
    end
  end

  // Compared-bit counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_count_q <= 48'd0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`else
  logic unused_bit_count_s;
  assign unused_bit_count_s = beat_locked_s;
  assign bit_count          = 48'd0;
`endif

  assign s_tready    = s_tready_q;
  assign locked      = locked_q;
  assign err_valid   = err_valid_q;
  assign err_bits    = err_bits_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_checker
//
// Directed bench for lfsr_prbs_checker using the default PRBS7 (x^7+x^6+1,
// 8-bit words). A second instance with a 4-bit error counter receives the
// same stimulus and shows saturation at 15.
//
// The PRBS stream comes from a serial reference generator seeded with 7'h7F.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic        clear_count;

  logic        s_tready,    s_tready_b;
  logic        locked,      locked_b;
  logic        err_valid,   err_valid_b;
  logic [3:0]  err_bits,    err_bits_b;
  logic [31:0] error_count;
  logic [3:0]  error_count_b;
  logic [47:0] bit_count,   bit_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Serial reference generator; sr[k-1] holds x[n-k]
  logic [6:0] gen_sr = 7'h7F;

  lfsr_prbs_checker dut (
    .clk         (clk),
    .rst         (rst),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .clear_count (clear_count),
    .locked      (locked),
    .err_valid   (err_valid),
    .err_bits    (err_bits),
    .error_count (error_count),
    .bit_count   (bit_count)
  );

  lfsr_prbs_checker #(.ERR_CNT_WIDTH(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready_b),
    .s_tdata     (s_tdata),
    .clear_count (clear_count),
    .locked      (locked_b),
    .err_valid   (err_valid_b),
    .err_bits    (err_bits_b),
    .error_count (error_count_b),
    .bit_count   (bit_count_b)
  );

  always #5 clk = ~clk;

`ifdef LFSR_PRBS_CHECKER_BIT_COUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  function automatic logic [63:0] exp_bc(input int n);
    return BC_EN ? 64'(n) : 64'd0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Produce the next 8 stream bits, oldest in bit 0
  task automatic next_word(output logic [7:0] w);
    logic nb;
    for (int i = 0; i < 8; i++) begin
      nb     = gen_sr[5] ^ gen_sr[6];
      gen_sr = {gen_sr[5:0], nb};
      w[i]   = nb;
    end
  endtask

  // Present one beat, then return #1 after the edge that accepts it
  task automatic send(input logic [7:0] d, input logic clr);
    s_tvalid    = 1'b1;
    s_tdata     = d;
    clear_count = clr;
    @(posedge clk);
    #1;
    s_tvalid    = 1'b0;
    clear_count = 1'b0;
  endtask

  // Send the next stream word XORed with an error mask
  task automatic send_prbs(input logic [7:0] mask, input logic clr);
    logic [7:0] w;
    next_word(w);
    send(w ^ mask, clr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    s_tvalid    = 1'b0;
    s_tdata     = 8'h00;
    clear_count = 1'b0;

    // Reset: held for 3 cycles, all outputs low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_tready",  64'(s_tready),    64'd0);
    check_eq("rst_locked",  64'(locked),      64'd0);
    check_eq("rst_errv",    64'(err_valid),   64'd0);
    check_eq("rst_errbits", 64'(err_bits),    64'd0);
    check_eq("rst_errcnt",  64'(error_count), 64'd0);
    check_eq("rst_bitcnt",  64'(bit_count),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tready_after_rst", 64'(s_tready), 64'd1);

    // Acquisition: the fifth beat locks the checker
    for (int b = 1; b <= 10; b++) begin
      send_prbs(8'h00, 1'b0);
      if (b == 4) check_eq("acq_unlocked_b4", 64'(locked), 64'd0);
      if (b == 5) check_eq("acq_locked_b5",   64'(locked), 64'd1);
    end
    check_eq("acq_errcnt", 64'(error_count), 64'd0);
    check_eq("acq_bitcnt", 64'(bit_count),   exp_bc(40));
    check_eq("acq_locked", 64'(locked),      64'd1);

    // Single error: bit 3 flipped in one beat
    send_prbs(8'h08, 1'b0);
    check_eq("se_errv",    64'(err_valid),   64'd1);
    check_eq("se_errbits", 64'(err_bits),    64'd1);
    check_eq("se_errcnt",  64'(error_count), 64'd1);
    check_eq("se_locked",  64'(locked),      64'd1);
    send_prbs(8'h00, 1'b0);
    check_eq("se_clean_errv",   64'(err_valid),   64'd0);
    check_eq("se_clean_errcnt", 64'(error_count), 64'd1);
    @(posedge clk);
    #1;
    check_eq("idle_errv",   64'(err_valid), 64'd0);
    check_eq("idle_locked", 64'(locked),    64'd1);
    send_prbs(8'h00, 1'b0);
    check_eq("se_bitcnt", 64'(bit_count), exp_bc(64));

    // Loss of lock: three fully inverted beats
    send_prbs(8'hFF, 1'b0);
    check_eq("lol1_errbits", 64'(err_bits),    64'd8);
    check_eq("lol1_errcnt",  64'(error_count), 64'd9);
    check_eq("lol1_locked",  64'(locked),      64'd1);
    send_prbs(8'hFF, 1'b0);
    check_eq("lol2_errcnt",  64'(error_count), 64'd17);
    check_eq("lol2_locked",  64'(locked),      64'd1);
    send_prbs(8'hFF, 1'b0);
    check_eq("lol3_errcnt",  64'(error_count), 64'd25);
    check_eq("lol3_locked",  64'(locked),      64'd0);
    check_eq("lol3_errv",    64'(err_valid),   64'd1);
    check_eq("sat_at_15",    64'(error_count_b), 64'd15);
    for (int b = 1; b <= 5; b++) begin
      send_prbs(8'h00, 1'b0);
      if (b == 4) check_eq("relock_b4", 64'(locked), 64'd0);
      if (b == 5) check_eq("relock_b5", 64'(locked), 64'd1);
    end
    check_eq("relock_errcnt", 64'(error_count), 64'd25);
    check_eq("relock_bitcnt", 64'(bit_count),   exp_bc(88));

    // Clear in the same cycle as a 2-bit error
    send_prbs(8'h11, 1'b1);
    check_eq("clr_err_errcnt",  64'(error_count),   64'd2);
    check_eq("clr_err_errbits", 64'(err_bits),      64'd2);
    check_eq("clr_err_sat",     64'(error_count_b), 64'd2);
    check_eq("clr_err_bitcnt",  64'(bit_count),     exp_bc(8));

    // Saturation: clear, then ten 2-bit errored beats separated by clean ones
    send_prbs(8'h00, 1'b1);
    check_eq("clr_clean_errcnt", 64'(error_count), 64'd0);
    for (int b = 1; b <= 10; b++) begin
      send_prbs(8'h03, 1'b0);
      if (b == 7) begin
        check_eq("sat_b7_wide",   64'(error_count),   64'd14);
        check_eq("sat_b7_narrow", 64'(error_count_b), 64'd14);
      end
      if (b == 8) begin
        check_eq("sat_b8_wide",   64'(error_count),   64'd16);
        check_eq("sat_b8_narrow", 64'(error_count_b), 64'd15);
      end
      send_prbs(8'h00, 1'b0);
    end
    check_eq("sat_end_wide",   64'(error_count),   64'd20);
    check_eq("sat_end_narrow", 64'(error_count_b), 64'd15);
    check_eq("sat_end_locked", 64'(locked),        64'd1);
    check_eq("sat_end_bitcnt", 64'(bit_count),     exp_bc(168));

    // Reset mid-stream clears everything
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_locked", 64'(locked),      64'd0);
    check_eq("midrst_errcnt", 64'(error_count), 64'd0);
    check_eq("midrst_tready", 64'(s_tready),    64'd0);
    check_eq("midrst_bitcnt", 64'(bit_count),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All-zero input keeps the checker hunting
    for (int b = 0; b < 20; b++) begin
      send(8'h00, 1'b0);
    end
    check_eq("zero_locked", 64'(locked),      64'd0);
    check_eq("zero_errcnt", 64'(error_count), 64'd0);
    check_eq("zero_errv",   64'(err_valid),   64'd0);
    for (int b = 1; b <= 5; b++) begin
      send_prbs(8'h00, 1'b0);
      if (b == 4) check_eq("zero_then_b4", 64'(locked), 64'd0);
      if (b == 5) check_eq("zero_then_b5", 64'(locked), 64'd1);
    end
    check_eq("zero_then_bitcnt", 64'(bit_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
